mem_word_access: RTL and testbench

Two-cycle word-access sequencer that sits directly upstream of the byte-wide system `Memory` (16-bit address, 8-bit data, active-low `CS`, `WR` 1 = write). It turns single 16-bit load/store requests from the CPU control path into two consecutive byte accesses at `Addr` and `Addr+1`, and assembles read bytes into a 16-bit result. An optional byte mode performs a single access.

---
 rtl/mem_word_access.sv | 157 +++++++++++++++
 tb/tb_mem_word_access.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_access.sv
// mem_word_access: two-cycle word-access sequencer in front of a byte-wide
// memory. A 16-bit load/store request becomes two byte accesses at Addr and
// Addr+1 (modulo 2^ADDR_W). In byte mode it becomes a single access at Addr.
//
// Ports:
//   Clock, Reset      clock; synchronous active-low reset
//   Req, Write,       request strobe and its attributes, all captured
//   ByteMode, Addr,   together in IDLE
//   WData
//   Busy, Done, RData status, one-cycle completion pulse, load result
//   MemAddress, MemData, MemWR, MemCS   memory strobes (CS active-low)
//   MemOut            read data from the memory, valid in the access cycle
//
// Build option: define WORD_ACCESS_BIG_ENDIAN_EN to place bits [15:8] at Addr
// and bits [7:0] at Addr+1. Byte mode is unaffected by this option.
module mem_word_access #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Write,
  input  logic              ByteMode,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       WData,
  output logic              Busy,
  output logic              Done,
  output logic [15:0]       RData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        MemData,
  output logic              MemWR,
  output logic              MemCS,
  input  logic [7:0]        MemOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [7:0]          byte0_q, byte0_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                done_q, done_d;

  logic [7:0]          first_byte;
  logic [7:0]          second_byte;
  logic [15:0]         word_read;

  // Byte lane mapping for word accesses; the first access goes to Addr.
  always_comb begin
`ifdef WORD_ACCESS_BIG_ENDIAN_EN
    first_byte  = wdata_q[15:8];
    second_byte = wdata_q[7:0];
    word_read   = {byte0_q, MemOut};
`else
    first_byte  = wdata_q[7:0];
    second_byte = wdata_q[15:8];
    word_read   = {MemOut, byte0_q};
`endif
  end

  // Next-state and capture logic. The first read byte is held in byte0_q so
  // RData only changes when the whole load completes.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    byte0_d = byte0_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          write_d = Write;
          byte_d  = ByteMode;
          addr_d  = Addr;
          wdata_d = WData;
          state_d = ACC0;
        end
      end
      ACC0: begin
        if (byte_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!write_q) rdata_d = {8'h00, MemOut};
        end else begin
          state_d = ACC1;
          byte0_d = MemOut;
        end
      end
      ACC1: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!write_q) rdata_d = word_read;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes are combinational from the current state.
  always_comb begin
    MemCS      = 1'b1;
    MemWR      = 1'b0;
    MemAddress = '0;
    MemData    = '0;
    unique case (state_q)
      ACC0: begin
        MemCS      = 1'b0;
        MemWR      = write_q;
        MemAddress = addr_q;
        MemData    = byte_q ? wdata_q[7:0] : first_byte;
      end
      ACC1: begin
        MemCS      = 1'b0;
        MemWR      = write_q;
        MemAddress = addr_q + ADDR_W'(1);
        MemData    = second_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      byte0_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      byte0_q <= byte0_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign Busy  = (state_q != IDLE);
  assign Done  = done_q;
  assign RData = rdata_q;

endmodule

// File: tb/tb_mem_word_access.sv
// Testbench for mem_word_access: directed vectors against a byte-wide RAM
// model. Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_word_access;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req;
  logic        Write;
  logic        ByteMode;
  logic [15:0] Addr;
  logic [15:0] WData;
  logic        Busy;
  logic        Done;
  logic [15:0] RData;
  logic [15:0] MemAddress;
  logic [7:0]  MemData;
  logic        MemWR;
  logic        MemCS;
  logic [7:0]  MemOut;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned acc_cnt  = 0;
  int unsigned cnt0;

  logic [7:0] ram [0:65535];

  mem_word_access #(.ADDR_W(16)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .Write      (Write),
    .ByteMode   (ByteMode),
    .Addr       (Addr),
    .WData      (WData),
    .Busy       (Busy),
    .Done       (Done),
    .RData      (RData),
    .MemAddress (MemAddress),
    .MemData    (MemData),
    .MemWR      (MemWR),
    .MemCS      (MemCS),
    .MemOut     (MemOut)
  );

  always #5 Clock = ~Clock;

  // Byte-wide memory: asynchronous read, write on the rising edge.
  assign MemOut = ram[MemAddress];
  always @(posedge Clock) begin
    if (!MemCS && MemWR) ram[MemAddress] <= MemData;
    if (!MemCS) acc_cnt <= acc_cnt + 1;
  end

`ifdef WORD_ACCESS_BIG_ENDIAN_EN
  localparam logic [15:0] EXP_LD10  = 16'h3412;
  localparam logic [15:0] EXP_WRAP  = 16'hAA55;
  localparam logic [7:0]  EXP_ST_LO = 8'hBE;  // byte at base address
  localparam logic [7:0]  EXP_ST_HI = 8'hEF;  // byte at base + 1
`else
  localparam logic [15:0] EXP_LD10  = 16'h1234;
  localparam logic [15:0] EXP_WRAP  = 16'h55AA;
  localparam logic [7:0]  EXP_ST_LO = 8'hEF;
  localparam logic [7:0]  EXP_ST_HI = 8'hBE;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
  endtask

  task automatic request(input logic wr, input logic bm, input logic [15:0] a, input logic [15:0] wd);
    Req = 1'b1; Write = wr; ByteMode = bm; Addr = a; WData = wd;
  endtask

  initial begin
    Reset = 1'b0; Req = 1'b0; Write = 1'b0; ByteMode = 1'b0; Addr = '0; WData = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0010] = 8'h34;
    ram[16'h0011] = 8'h12;
    ram[16'hFFFF] = 8'hAA;
    ram[16'h0000] = 8'h55;

    repeat (2) cyc();
    check("rst_busy",  Busy, 0);
    check("rst_done",  Done, 0);
    check("rst_rdata", RData, 16'h0000);
    check("rst_cs",    MemCS, 1);
    check("rst_wr",    MemWR, 0);
    check("rst_addr",  MemAddress, 16'h0000);
    check("rst_data",  MemData, 8'h00);
    Reset = 1'b1;
    cyc();

    // Word load from 0x0010
    request(1'b0, 1'b0, 16'h0010, 16'h0000);
    cyc();
    check("ld_a0_addr", MemAddress, 16'h0010);
    check("ld_a0_cs",   MemCS, 0);
    check("ld_a0_wr",   MemWR, 0);
    check("ld_a0_busy", Busy, 1);
    check("ld_a0_done", Done, 0);
    Req = 1'b0;
    cyc();
    check("ld_a1_addr", MemAddress, 16'h0011);
    check("ld_a1_cs",   MemCS, 0);
    check("ld_a1_done", Done, 0);
    cyc();
    check("ld_done",  Done, 1);
    check("ld_rdata", RData, EXP_LD10);
    check("ld_busy",  Busy, 0);
    check("ld_cs",    MemCS, 1);
    cyc();
    check("ld_done_pulse", Done, 0);

    // Word store 0xBEEF to 0x0200
    request(1'b1, 1'b0, 16'h0200, 16'hBEEF);
    cyc();
    check("st_a0_wr",   MemWR, 1);
    check("st_a0_data", MemData, EXP_ST_LO);
    Req = 1'b0;
    cyc();
    check("st_a1_addr", MemAddress, 16'h0201);
    check("st_a1_data", MemData, EXP_ST_HI);
    cyc();
    check("st_done",      Done, 1);
    check("st_rdata_keep", RData, EXP_LD10);
    check("st_ram0",      ram[16'h0200], EXP_ST_LO);
    check("st_ram1",      ram[16'h0201], EXP_ST_HI);

    // Load back the stored word
    request(1'b0, 1'b0, 16'h0200, 16'h0000);
    cyc();
    Req = 1'b0;
    repeat (2) cyc();
    check("rb_done",  Done, 1);
    check("rb_rdata", RData, 16'hBEEF);

    // Wrap-around at 0xFFFF
    request(1'b0, 1'b0, 16'hFFFF, 16'h0000);
    cyc();
    check("wr_a0_addr", MemAddress, 16'hFFFF);
    Req = 1'b0;
    cyc();
    check("wr_a1_addr", MemAddress, 16'h0000);
    cyc();
    check("wr_rdata", RData, EXP_WRAP);

    // Byte load, back-to-back word load, Req held while busy
    cnt0 = acc_cnt;
    request(1'b0, 1'b1, 16'h0010, 16'h0000);
    cyc();
    check("bt_addr", MemAddress, 16'h0010);
    check("bt_busy", Busy, 1);
    request(1'b0, 1'b0, 16'h0010, 16'h0000);
    cyc();
    check("bt_done",  Done, 1);
    check("bt_rdata", RData, 16'h0034);
    check("bt_busy0", Busy, 0);
    cyc();
    check("b2b_a0_addr", MemAddress, 16'h0010);
    check("b2b_busy",    Busy, 1);
    check("b2b_done",    Done, 0);
    Addr = 16'h0200;
    cyc();
    check("b2b_a1_addr", MemAddress, 16'h0011);
    cyc();
    check("b2b_done1", Done, 1);
    check("b2b_rdata", RData, EXP_LD10);
    Req = 1'b0;
    cyc();
    check("b2b_idle",    Busy, 0);
    check("b2b_acc_cnt", acc_cnt - cnt0, 3);

    // Reset during ACC1 of a store
    request(1'b1, 1'b0, 16'h0300, 16'hBEEF);
    cyc();
    Req = 1'b0;
    cyc();
    check("rs_a1_addr", MemAddress, 16'h0301);
    Reset = 1'b0;
    request(1'b0, 1'b0, 16'h0010, 16'h0000);
    cyc();
    check("rs_busy",  Busy, 0);
    check("rs_done",  Done, 0);
    check("rs_rdata", RData, 16'h0000);
    check("rs_cs",    MemCS, 1);
    check("rs_wr",    MemWR, 0);
    check("rs_addr",  MemAddress, 16'h0000);
    check("rs_data",  MemData, 8'h00);
    Reset = 1'b1;
    Req = 1'b0;
    cnt0 = acc_cnt;
    cyc();
    check("rs_done1", Done, 0);
    check("rs_busy1", Busy, 0);
    cyc();
    check("rs_done2",    Done, 0);
    check("rs_no_acc",   acc_cnt - cnt0, 0);
    check("rs_ram0",     ram[16'h0300], EXP_ST_LO);
    check("rs_ram1",     ram[16'h0301], EXP_ST_HI);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
